// File: rtl/dmem_port_arbiter.sv
// Shares the data-memory SRAM port between the CPU MEM stage (fixed priority) and an
// external master (starvation-forced and locked-burst grants). Optional perf counters: DMEM_ARB_PERF_CNT_EN.
module dmem_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              cpu_req_valid,
  input  logic              cpu_wen,
  input  logic [DATA_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req_valid,
  input  logic              ext_wen,
  input  logic              ext_lock,
  input  logic [DATA_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ready,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic              mem_ren,
  output logic [DATA_W-1:0] mem_wdata,
`ifdef DMEM_ARB_PERF_CNT_EN
  input  logic              perf_clr,
  output logic [31:0]       cpu_stall_cnt,
  output logic [31:0]       ext_wait_cnt,
`endif
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int WAIT_W = $clog2(MAX_WAIT) + 1;
  localparam int LOCK_W = $clog2(MAX_LOCK) + 1;

  localparam logic [1:0] ST_CPU_PRI   = 2'd0;
  localparam logic [1:0] ST_EXT_FORCE = 2'd1;
  localparam logic [1:0] ST_EXT_LOCK  = 2'd2;

  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
  localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(MAX_LOCK - 1);
  // A one-beat burst limit means a locked beat never opens a burst.
  localparam logic              LOCK_OK   = (MAX_LOCK > 1);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_owner_q, rsp_owner_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

  logic ext_pri, ext_gnt, cpu_gnt;

  always_comb begin
    ext_pri = (state_q != ST_CPU_PRI);
    ext_gnt = ext_req_valid & (ext_pri | ~cpu_req_valid);
    cpu_gnt = cpu_req_valid & ~ext_gnt;
  end

  assign cpu_stall = cpu_req_valid & ~cpu_gnt;
  assign ext_ready = ext_gnt;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wen   = 1'b0;
    mem_ren   = 1'b0;
    if (ext_gnt) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
      mem_wen   = ext_wen;
      mem_ren   = ~ext_wen;
    end else if (cpu_gnt) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
      mem_wen   = cpu_wen;
      mem_ren   = ~cpu_wen;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    // Any grant or an idle ext cycle restarts the count, so a force never follows a burst directly.
    wait_cnt_d = (ext_req_valid & ~ext_gnt) ? wait_cnt_q + WAIT_ONE : '0;
    case (state_q)
      ST_CPU_PRI: begin
        if (ext_gnt && ext_lock && LOCK_OK) begin
          state_d    = ST_EXT_LOCK;
          lock_cnt_d = LOCK_ONE;
        end else if (ext_req_valid && !ext_gnt && wait_cnt_q == WAIT_LAST) begin
          state_d = ST_EXT_FORCE;
        end
      end
      ST_EXT_FORCE: begin
        if (ext_gnt && ext_lock && LOCK_OK) begin
          state_d    = ST_EXT_LOCK;
          lock_cnt_d = LOCK_ONE;
        end else begin
          state_d = ST_CPU_PRI;
        end
      end
      ST_EXT_LOCK: begin
        if (!ext_req_valid || !ext_lock || lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_CPU_PRI;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_ONE;
        end
      end
      default: begin
        state_d    = ST_CPU_PRI;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Read data returns one cycle after the issuing beat; rsp_owner steers it.
  always_comb begin
    rsp_valid_d = mem_ren;
    rsp_owner_d = mem_ren ? ext_gnt : rsp_owner_q;
    cpu_rdata_d = (rsp_valid_q & ~rsp_owner_q) ? mem_rdata : cpu_rdata_q;
  end

  assign cpu_rdata  = cpu_rdata_d;
  assign ext_rvalid = rsp_valid_q & rsp_owner_q;
  assign ext_rdata  = ext_rvalid ? mem_rdata : '0;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q     <= ST_CPU_PRI;
      wait_cnt_q  <= '0;
      lock_cnt_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      cpu_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_owner_q <= rsp_owner_d;
      cpu_rdata_q <= cpu_rdata_d;
    end
  end

`ifdef DMEM_ARB_PERF_CNT_EN
  logic [31:0] cpu_stall_cnt_q, cpu_stall_cnt_d;
  logic [31:0] ext_wait_cnt_q, ext_wait_cnt_d;

  always_comb begin
    cpu_stall_cnt_d = cpu_stall_cnt_q;
    ext_wait_cnt_d  = ext_wait_cnt_q;
    if (perf_clr) begin
      cpu_stall_cnt_d = '0;
      ext_wait_cnt_d  = '0;
    end else begin
      if (cpu_stall && !(&cpu_stall_cnt_q))
        cpu_stall_cnt_d = cpu_stall_cnt_q + 32'd1;
      if (ext_req_valid && !ext_gnt && !(&ext_wait_cnt_q))
        ext_wait_cnt_d = ext_wait_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cpu_stall_cnt_q <= '0;
      ext_wait_cnt_q  <= '0;
    end else begin
      cpu_stall_cnt_q <= cpu_stall_cnt_d;
      ext_wait_cnt_q  <= ext_wait_cnt_d;
    end
  end

  assign cpu_stall_cnt = cpu_stall_cnt_q;
  assign ext_wait_cnt  = ext_wait_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed scenarios plus randomized traffic against a
// cycle-level reference model of the arbitration rules and a reference memory image.
module tb_dmem_port_arbiter;
  localparam int DW       = 32;
  localparam int MAX_WAIT = 8;
  localparam int MAX_LOCK = 4;

  logic          clk = 1'b0;
  logic          arst_n = 1'b1;
  logic          cpu_req_valid, cpu_wen;
  logic [DW-1:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic          cpu_stall;
  logic          ext_req_valid, ext_wen, ext_lock;
  logic [DW-1:0] ext_addr, ext_wdata, ext_rdata;
  logic          ext_ready, ext_rvalid;
  logic [DW-1:0] mem_addr, mem_wdata;
  logic          mem_wen, mem_ren;
  logic [DW-1:0] mem_rdata = '0;
`ifdef DMEM_ARB_PERF_CNT_EN
  logic          perf_clr;
  logic [31:0]   cpu_stall_cnt, ext_wait_cnt;
`endif

  logic [DW-1:0] sram [256] = '{default: '0};
  int n_checks = 0;
  int n_pass   = 0;

  logic [4*DW+4:0] all_out;
  assign all_out = {cpu_rdata, cpu_stall, ext_ready, ext_rvalid, ext_rdata,
                    mem_addr, mem_wen, mem_ren, mem_wdata};

  dmem_port_arbiter #(.DATA_W(DW), .MAX_WAIT(MAX_WAIT), .MAX_LOCK(MAX_LOCK)) dut (
    .clk(clk), .arst_n(arst_n),
    .cpu_req_valid(cpu_req_valid), .cpu_wen(cpu_wen), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req_valid(ext_req_valid), .ext_wen(ext_wen), .ext_lock(ext_lock),
    .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ready(ext_ready),
    .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata),
    .mem_addr(mem_addr), .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_wdata(mem_wdata),
`ifdef DMEM_ARB_PERF_CNT_EN
    .perf_clr(perf_clr), .cpu_stall_cnt(cpu_stall_cnt), .ext_wait_cnt(ext_wait_cnt),
`endif
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // SRAM with one-cycle read latency.
  always @(posedge clk) begin
    if (mem_wen) sram[mem_addr[9:2]] <= mem_wdata;
    if (mem_ren) mem_rdata <= sram[mem_addr[9:2]];
  end

  task automatic idle_inputs();
    cpu_req_valid = 1'b0; cpu_wen = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req_valid = 1'b0; ext_wen = 1'b0; ext_lock = 1'b0; ext_addr = '0; ext_wdata = '0;
`ifdef DMEM_ARB_PERF_CNT_EN
    perf_clr = 1'b0;
`endif
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    idle_inputs();
    arst_n = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 arst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) $display("FAIL reset_outputs got=%h exp=0", all_out);
    else n_pass++;
    arst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) $display("FAIL reset_release_outputs got=%h exp=0", all_out);
    else n_pass++;
`ifdef DMEM_ARB_PERF_CNT_EN
    n_checks++;
    if ({cpu_stall_cnt, ext_wait_cnt} !== 64'd0)
      $display("FAIL reset_perf got=%h exp=0", {cpu_stall_cnt, ext_wait_cnt});
    else n_pass++;
`endif
  endtask

  task automatic test_cpu_only();
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h10; cpu_wdata = 32'hDEADBEEF;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, mem_wen, mem_ren, mem_addr, mem_wdata} !== {3'b010, 32'h10, 32'hDEADBEEF})
      $display("FAIL cpu_write_issue got=%h exp=%h", {cpu_stall, mem_wen, mem_ren, mem_addr, mem_wdata},
               {3'b010, 32'h10, 32'hDEADBEEF});
    else n_pass++;
    @(posedge clk); #1;
    cpu_wen = 1'b0; cpu_wdata = '0;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, mem_wen, mem_ren, mem_addr} !== {3'b001, 32'h10})
      $display("FAIL cpu_read_issue got=%h exp=%h", {cpu_stall, mem_wen, mem_ren, mem_addr}, {3'b001, 32'h10});
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({mem_wen, cpu_rdata} !== {1'b0, 32'hDEADBEEF})
      $display("FAIL cpu_read_data got=%h exp=%h", {mem_wen, cpu_rdata}, {1'b0, 32'hDEADBEEF});
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if (cpu_rdata !== 32'hDEADBEEF) $display("FAIL cpu_rdata_hold got=%h exp=deadbeef", cpu_rdata);
    else n_pass++;
  endtask

  task automatic test_ext_only();
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_wen = 1'b1; cpu_addr = 32'h20; cpu_wdata = 32'h55;
    @(posedge clk); #1;
    idle_inputs();
    ext_req_valid = 1'b1; ext_wen = 1'b0; ext_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if ({ext_ready, mem_ren, mem_addr, ext_rvalid} !== {2'b11, 32'h20, 1'b0})
      $display("FAIL ext_read_issue got=%h exp=%h", {ext_ready, mem_ren, mem_addr, ext_rvalid}, {2'b11, 32'h20, 1'b0});
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    n_checks++;
    if ({ext_rvalid, ext_rdata, cpu_rdata} !== {1'b1, 32'h55, 32'hDEADBEEF})
      $display("FAIL ext_read_rsp got=%h exp=%h", {ext_rvalid, ext_rdata, cpu_rdata}, {1'b1, 32'h55, 32'hDEADBEEF});
    else n_pass++;
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++;
    if ({ext_rvalid, ext_rdata} !== 33'd0) $display("FAIL ext_rsp_clear got=%h exp=0", {ext_rvalid, ext_rdata});
    else n_pass++;
  endtask

  task automatic test_starvation();
    logic exp_hit;
    @(posedge clk); #1;
    idle_inputs();
`ifdef DMEM_ARB_PERF_CNT_EN
    perf_clr = 1'b1;
`endif
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
`ifdef DMEM_ARB_PERF_CNT_EN
      perf_clr = 1'b0;
`endif
      cpu_req_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h10;
      ext_req_valid = 1'b1; ext_wen = 1'b1; ext_lock = 1'b0; ext_addr = 32'h40; ext_wdata = 32'(c);
      @(negedge clk);
      exp_hit = (c == 8);
      n_checks++;
      if ({ext_ready, cpu_stall} !== {exp_hit, exp_hit})
        $display("FAIL starve_cycle%0d got ready/stall=%b%b exp=%b%b", c, ext_ready, cpu_stall, exp_hit, exp_hit);
      else n_pass++;
`ifdef DMEM_ARB_PERF_CNT_EN
      if (c == 9) begin
        n_checks++;
        if ({ext_wait_cnt, cpu_stall_cnt} !== {32'd8, 32'd1})
          $display("FAIL starve_perf got wait=%0d stall=%0d exp wait=8 stall=1", ext_wait_cnt, cpu_stall_cnt);
        else n_pass++;
      end
`endif
    end
    @(posedge clk); #1;
    idle_inputs();
`ifdef DMEM_ARB_PERF_CNT_EN
    perf_clr = 1'b1;
    @(posedge clk); #1;
    perf_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ext_wait_cnt, cpu_stall_cnt} !== 64'd0)
      $display("FAIL perf_clr got wait=%0d stall=%0d exp 0 0", ext_wait_cnt, cpu_stall_cnt);
    else n_pass++;
`endif
  endtask

  task automatic test_lock_burst();
    logic exp_rdy, exp_stl;
    @(posedge clk); #1;
    idle_inputs();
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      cpu_req_valid = (c != 0); cpu_wen = 1'b0; cpu_addr = 32'h10;
      ext_req_valid = 1'b1; ext_wen = 1'b1; ext_lock = 1'b1; ext_addr = 32'h60; ext_wdata = 32'hA0 + 32'(c);
      @(negedge clk);
      exp_rdy = (c < 4);
      exp_stl = (c >= 1) && (c < 4);
      n_checks++;
      if ({ext_ready, cpu_stall} !== {exp_rdy, exp_stl})
        $display("FAIL lock_cycle%0d got ready/stall=%b%b exp=%b%b", c, ext_ready, cpu_stall, exp_rdy, exp_stl);
      else n_pass++;
    end
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    @(posedge clk); #1;
    idle_inputs();
    ext_req_valid = 1'b1; ext_wen = 1'b0; ext_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if (ext_ready !== 1'b1) $display("FAIL midrd_accept got=%b exp=1", ext_ready);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    arst_n = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_out !== '0) $display("FAIL midrd_outputs got=%h exp=0", all_out);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (ext_rvalid !== 1'b0) $display("FAIL midrd_rvalid got=%b exp=0", ext_rvalid);
    else n_pass++;
    arst_n = 1'b1;
    @(posedge clk); #1;
    cpu_req_valid = 1'b1; cpu_wen = 1'b0; cpu_addr = 32'h10;
    ext_req_valid = 1'b1; ext_wen = 1'b0; ext_addr = 32'h20;
    @(negedge clk);
    n_checks++;
    if ({cpu_stall, ext_ready, ext_rvalid, mem_addr} !== {3'b000, 32'h10})
      $display("FAIL midrd_cpu_pri got=%h exp=%h", {cpu_stall, ext_ready, ext_rvalid, mem_addr}, {3'b000, 32'h10});
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_random();
    int          ext_wait, burst, stall_cycles, wait_cycles;
    bit          force_pend, pend_v, pend_ext, cpu_held, ext_held, g_ext, g_cpu, any_g, a_wen;
    logic [31:0] pend_d, cpu_hold, a_addr, a_wdata;
    logic [31:0] ref_mem [16];
    logic [67:0] exp_iss, got_iss;
    logic [64:0] exp_rsp, got_rsp;
    ext_wait = 0; burst = 0; stall_cycles = 0; wait_cycles = 0;
    force_pend = 0; pend_v = 0; pend_ext = 0; cpu_held = 0; ext_held = 0;
    pend_d = '0; cpu_hold = '0;
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (!cpu_held) begin
        cpu_req_valid = ($urandom_range(0, 99) < 80);
        cpu_wen       = 1'($urandom_range(0, 1));
        cpu_addr      = 32'h100 | ($urandom_range(0, 15) << 2);
        cpu_wdata     = $urandom;
      end
      if (!ext_held) begin
        ext_req_valid = ($urandom_range(0, 99) < 50);
        ext_wen       = 1'($urandom_range(0, 1));
        ext_lock      = 1'($urandom_range(0, 1));
        ext_addr      = 32'h100 | ($urandom_range(0, 15) << 2);
        ext_wdata     = $urandom;
      end
      @(negedge clk);
      // Ext outranks the CPU while a force is pending or a burst is open.
      g_ext   = ext_req_valid && (!cpu_req_valid || force_pend || burst > 0);
      g_cpu   = cpu_req_valid && !g_ext;
      any_g   = g_ext || g_cpu;
      a_wen   = g_ext ? ext_wen : cpu_wen;
      a_addr  = !any_g ? 32'h0 : (g_ext ? ext_addr : cpu_addr);
      a_wdata = !any_g ? 32'h0 : (g_ext ? ext_wdata : cpu_wdata);
      exp_iss = {(cpu_req_valid && !g_cpu), g_ext, (any_g && a_wen), (any_g && !a_wen), a_addr, a_wdata};
      got_iss = {cpu_stall, ext_ready, mem_wen, mem_ren, mem_addr, mem_wdata};
      n_checks++;
      if (got_iss !== exp_iss) $display("FAIL rand_issue cycle%0d got=%h exp=%h", c, got_iss, exp_iss);
      else n_pass++;
      exp_rsp = {(pend_v && pend_ext), (pend_v && pend_ext) ? pend_d : 32'h0,
                 (pend_v && !pend_ext) ? pend_d : cpu_hold};
      got_rsp = {ext_rvalid, ext_rdata, cpu_rdata};
      n_checks++;
      if (got_rsp !== exp_rsp) $display("FAIL rand_rsp cycle%0d got=%h exp=%h", c, got_rsp, exp_rsp);
      else n_pass++;
      if (pend_v && !pend_ext) cpu_hold = pend_d;
      pend_v = 0;
      if (any_g) begin
        if (a_wen) ref_mem[a_addr[5:2]] = a_wdata;
        else begin
          pend_v = 1; pend_ext = g_ext; pend_d = ref_mem[a_addr[5:2]];
        end
      end
      if (cpu_req_valid && !g_cpu) stall_cycles++;
      if (ext_req_valid && !g_ext) wait_cycles++;
      if (!ext_req_valid) begin
        ext_wait = 0; force_pend = 0; burst = 0;
      end else if (g_ext) begin
        ext_wait = 0; force_pend = 0;
        burst = (ext_lock && burst + 1 < MAX_LOCK) ? burst + 1 : 0;
      end else begin
        ext_wait++;
        if (ext_wait >= MAX_WAIT) force_pend = 1;
      end
      cpu_held = cpu_req_valid && !g_cpu;
      ext_held = ext_req_valid && !g_ext;
    end
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
`ifdef DMEM_ARB_PERF_CNT_EN
    n_checks++;
    if ({cpu_stall_cnt, ext_wait_cnt} !== {32'(stall_cycles), 32'(wait_cycles)})
      $display("FAIL rand_perf got stall=%0d wait=%0d exp stall=%0d wait=%0d",
               cpu_stall_cnt, ext_wait_cnt, stall_cycles, wait_cycles);
    else n_pass++;
`endif
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_cpu_only();
    test_ext_only();
    test_starvation();
    test_lock_burst();
    test_reset_mid_read();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
